// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 data memory controller and its storage array:
// controller FSM states, Y86 status codes and instruction codes used by the
// address/data selection logic around the memory stage.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Y86 status codes; a memory error response is reported to the core as SADR
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Y86 instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Map a memory error flag onto the status the core records
    function automatic logic [2:0] dmem_stat(input logic err);
        return err ? SADR : SAOK;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane data storage: one synchronous BYTES-wide write port, one registered
// read port (cleared on request) and one combinational debug read port.
// Both ports perform the address range check; the array itself is never reset.
module dmem_array
    import y86_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_err,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    // Highest legal start address; compared at full address width so wrap cannot pass
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - BYTES);

    logic [7:0]        mem [DEPTH];
    logic [IDX_W-1:0]  acc_idx;
    logic [IDX_W-1:0]  dbg_idx;
    logic              dbg_err;
    logic [DATA_W-1:0] acc_quad;
    logic [DATA_W-1:0] dbg_quad;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    assign acc_idx  = acc_addr[IDX_W-1:0];
    assign dbg_idx  = dbg_addr[IDX_W-1:0];
    assign acc_err  = (acc_addr > LAST_ADDR);
    assign dbg_err  = (dbg_addr > LAST_ADDR);
    assign dbg_data = dbg_err ? '0 : dbg_quad;
    assign rdata    = rdata_q;

    // Gather the little-endian quads addressed by the access and debug ports
    always_comb begin
        acc_quad = '0;
        dbg_quad = '0;
        for (int i = 0; i < BYTES; i++) begin
            acc_quad[8*i +: 8] = mem[acc_idx + IDX_W'(i)];
            dbg_quad[8*i +: 8] = mem[dbg_idx + IDX_W'(i)];
        end
    end

    // Commit every byte lane of an in-range store
    always_ff @(posedge clk) begin
        if (acc_en && acc_we && !acc_err) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[acc_idx + IDX_W'(i)] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Read register: load data on an error-free load, zero for stores/errors, clear on request
    always_comb begin
        rdata_d = rdata_q;
        if (rd_clr) begin
            rdata_d = '0;
        end else if (acc_en) begin
            rdata_d = (acc_we || acc_err) ? '0 : acc_quad;
        end
    end

    // Read register update with synchronous clear on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory for the Y86 core: valid/ready request and response
// handshakes, LATENCY-cycle access, address-error responses, debug read port.
// Optional macro DMEM_PERF_EN adds 32-bit load/store/error completion counters.
module dmem_ctrl
    import y86_mem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
`ifdef DMEM_PERF_EN
    output logic [31:0]       perf_rd,
    output logic [31:0]       perf_wr,
    output logic [31:0]       perf_err,
`endif
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;

    logic              enter_resp;
    logic              handshake;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_err;

    // With LATENCY==1 the access happens on the accept edge, so the array sees
    // the live request while idle and the latched request afterwards.
    assign acc_we    = (state_q == IDLE) ? req_write : wr_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_en    (enter_resp && rst_n),
        .acc_we    (acc_we),
        .rd_clr    (handshake),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_err   (acc_err),
        .rdata     (resp_rdata),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_error_d = resp_error_q;
        enter_resp   = 1'b0;
        handshake    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_error_d = acc_err;
        end
        if (handshake) begin
            resp_valid_d = 1'b0;
            resp_error_d = 1'b0;
        end
        req_ready_d = (state_d == IDLE);
    end

    // FSM state and registered outputs; the latched request is not reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
        end
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

`ifdef DMEM_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_err_q, perf_err_d;

    assign perf_rd  = perf_rd_q;
    assign perf_wr  = perf_wr_q;
    assign perf_err = perf_err_q;

    // Classify each completed response on its handshake; counters wrap naturally
    always_comb begin
        perf_rd_d  = perf_rd_q;
        perf_wr_d  = perf_wr_q;
        perf_err_d = perf_err_q;
        if (handshake) begin
            if (resp_error_q) begin
                perf_err_d = perf_err_q + 32'd1;
            end else if (wr_q) begin
                perf_wr_d = perf_wr_q + 32'd1;
            end else begin
                perf_rd_d = perf_rd_q + 32'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_rd_q  <= '0;
            perf_wr_q  <= '0;
            perf_err_q <= '0;
        end else begin
            perf_rd_q  <= perf_rd_d;
            perf_wr_q  <= perf_wr_d;
            perf_err_q <= perf_err_d;
        end
    end
`endif

endmodule
